// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32x32 storage, two async read ports, commit counter.
// Optional same-cycle write-to-read forwarding is enabled by defining WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Mem2R_WB,
    input  logic             RegW_WB,
    input  logic [31:0]      dmDataOut_WB,
    input  logic [31:0]      aluDataOut_WB,
    input  logic [4:0]       WB_rfWeSel,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    output logic [31:0]      rsData_ID,
    output logic [31:0]      rtData_ID,
    output logic [31:0]      wbData,
    output logic [CNT_W-1:0] wbCount
);

    logic [31:0]      regs [32];
    logic [CNT_W-1:0] count_q;
    logic             commit;

    assign wbData  = Mem2R_WB ? dmDataOut_WB : aluDataOut_WB;
    assign commit  = RegW_WB && (WB_rfWeSel != 5'd0);
    assign wbCount = count_q;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
            count_q <= '0;
        end else if (commit) begin
            regs[WB_rfWeSel] <= wbData;
            count_q          <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        rsData_ID = regs[rs_ID];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rs_ID == WB_rfWeSel)) begin
            rsData_ID = wbData;
        end
`endif
        // Reset and index 0 override any forwarded value.
        if (Rst || (rs_ID == 5'd0)) begin
            rsData_ID = '0;
        end
    end

    always_comb begin
        rtData_ID = regs[rt_ID];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rt_ID == WB_rfWeSel)) begin
            rtData_ID = wbData;
        end
`endif
        if (Rst || (rt_ID == 5'd0)) begin
            rtData_ID = '0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based reference model.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst;
    logic        we, m2r;
    logic [31:0] dm, alu;
    logic [4:0]  sel, rs, rt;

    logic [31:0] rs_d, rt_d, wb_d;
    logic [15:0] count;
    logic [31:0] rs4, rt4, wb4;
    logic [3:0]  count4;

    logic [31:0] model [32];
    int unsigned cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 Clk = ~Clk;

    wb_regfile dut (
        .Clk(Clk), .Rst(Rst), .Mem2R_WB(m2r), .RegW_WB(we),
        .dmDataOut_WB(dm), .aluDataOut_WB(alu), .WB_rfWeSel(sel),
        .rs_ID(rs), .rt_ID(rt), .rsData_ID(rs_d), .rtData_ID(rt_d),
        .wbData(wb_d), .wbCount(count)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Mem2R_WB(m2r), .RegW_WB(we),
        .dmDataOut_WB(dm), .aluDataOut_WB(alu), .WB_rfWeSel(sel),
        .rs_ID(rs), .rt_ID(rt), .rsData_ID(rs4), .rtData_ID(rt4),
        .wbData(wb4), .wbCount(count4)
    );

    function automatic logic [31:0] exp_wb();
        return m2r ? dm : alu;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] idx);
        if (Rst || idx == 5'd0) return 32'h0;
        if (BYP && we && sel != 5'd0 && idx == sel) return exp_wb();
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        cnt = 0;
    endtask

    task automatic drive(input logic w, input logic m, input logic [31:0] d,
                         input logic [31:0] a, input logic [4:0] s,
                         input logic [4:0] ra, input logic [4:0] rb);
        we = w; m2r = m; dm = d; alu = a; sel = s; rs = ra; rt = rb;
    endtask

    task automatic commit_edge();
        @(posedge Clk);
        if (!Rst && we && sel != 5'd0) begin
            model[sel] = exp_wb();
            cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom, 5'd5, 5'd5, 5'(i + 1));
            @(negedge Clk);
            n_cmp++;
            if (rs_d !== 32'h0 || rt_d !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_read got %h/%h want 0", rs_d, rt_d);
            end
            n_cmp++;
            if (count !== 16'h0) begin
                n_bad++;
                $display("FAIL reset_count got %0d want 0", count);
            end
            n_cmp++;
            if (wb_d !== exp_wb()) begin
                n_bad++;
                $display("FAIL reset_wbdata got %h want %h", wb_d, exp_wb());
            end
            commit_edge();
        end
        Rst = 1'b0;
        clear_model();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_basic_write();
        drive(1'b1, 1'b0, $urandom, 32'h12345678, 5'd5, 5'd0, 5'd0);
        commit_edge();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd5, 5'd5, 5'd0);
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== 32'h12345678) begin
            n_bad++;
            $display("FAIL basic_read got %h want 12345678", rs_d);
        end
        n_cmp++;
        if (count !== 16'd1) begin
            n_bad++;
            $display("FAIL basic_count got %0d want 1", count);
        end
        commit_edge();
    endtask

    task automatic test_zero_write();
        drive(1'b1, 1'b1, 32'hDEADBEEF, $urandom, 5'd0, 5'd0, 5'd0);
        @(negedge Clk);
        n_cmp++;
        if (wb_d !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL zero_wbdata got %h want deadbeef", wb_d);
        end
        n_cmp++;
        if (rs_d !== 32'h0 || rt_d !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_bypass got %h/%h want 0", rs_d, rt_d);
        end
        commit_edge();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== 32'h0 || count !== 16'd1) begin
            n_bad++;
            $display("FAIL zero_after got rs %h cnt %0d want 0 cnt 1", rs_d, count);
        end
        commit_edge();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        drive(1'b1, 1'b0, $urandom, 32'h1, 5'd7, 5'd0, 5'd0);
        commit_edge();
        drive(1'b1, 1'b0, $urandom, 32'hAAAA5555, 5'd7, 5'd7, 5'd7);
        want = BYP ? 32'hAAAA5555 : 32'h00000001;
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== want || rt_d !== want) begin
            n_bad++;
            $display("FAIL bypass_same got %h/%h want %h", rs_d, rt_d, want);
        end
        commit_edge();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== 32'hAAAA5555 || rt_d !== 32'hAAAA5555) begin
            n_bad++;
            $display("FAIL bypass_next got %h/%h want aaaa5555", rs_d, rt_d);
        end
        n_cmp++;
        if (count !== 16'(cnt)) begin
            n_bad++;
            $display("FAIL bypass_count got %0d want %0d", count, cnt);
        end
        commit_edge();
    endtask

    task automatic test_random();
        logic [4:0] s, a, b;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            a = ($urandom_range(0, 3) == 0) ? s : 5'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom);
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, s, a, b);
            @(negedge Clk);
            n_cmp++;
            if (wb_d !== exp_wb()) begin
                n_bad++;
                $display("FAIL rnd_wbdata got %h want %h", wb_d, exp_wb());
            end
            n_cmp++;
            if (rs_d !== exp_rd(rs)) begin
                n_bad++;
                $display("FAIL rnd_rs idx %0d got %h want %h", rs, rs_d, exp_rd(rs));
            end
            n_cmp++;
            if (rt_d !== exp_rd(rt)) begin
                n_bad++;
                $display("FAIL rnd_rt idx %0d got %h want %h", rt, rt_d, exp_rd(rt));
            end
            n_cmp++;
            if (count !== 16'(cnt) || count4 !== 4'(cnt)) begin
                n_bad++;
                $display("FAIL rnd_count got %0d/%0d want %0d", count, count4, cnt);
            end
            commit_edge();
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, $urandom, $urandom, 5'd9, 5'd9, 5'd9);
        #1 Rst = 1'b1;
        #1;
        n_cmp++;
        if (rs_d !== 32'h0 || rt_d !== 32'h0 || count !== 16'h0 || count4 !== 4'h0) begin
            n_bad++;
            $display("FAIL midrst_async got %h/%h cnt %0d want 0", rs_d, rt_d, count);
        end
        #1 Rst = 1'b0;
        clear_model();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom), 5'(i), 5'(i + 16));
            @(negedge Clk);
            n_cmp++;
            if (rs_d !== 32'h0 || rt_d !== 32'h0 || count !== 16'h0) begin
                n_bad++;
                $display("FAIL midrst_read idx %0d got %h/%h cnt %0d want 0", i, rs_d, rt_d, count);
            end
            commit_edge();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom,
                  5'($urandom_range(1, 31)), 5'd0, 5'd0);
            commit_edge();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(negedge Clk);
        n_cmp++;
        if (count4 !== 4'd1) begin
            n_bad++;
            $display("FAIL wrap_cnt4 got %0d want 1", count4);
        end
        n_cmp++;
        if (count !== 16'd17) begin
            n_bad++;
            $display("FAIL wrap_cnt16 got %0d want 17", count);
        end
        commit_edge();
    endtask

    task automatic test_reset_coincident();
        drive(1'b1, 1'b0, $urandom, 32'hFFFFFFFF, 5'd3, 5'd0, 5'd0);
        @(negedge Clk);
        #4 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        clear_model();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== 32'h0 || rt_d !== 32'h0 || count !== 16'h0) begin
            n_bad++;
            $display("FAIL coinc_rst got %h/%h cnt %0d want 0", rs_d, rt_d, count);
        end
        commit_edge();
        drive(1'b1, 1'b1, 32'h00C0FFEE, $urandom, 5'd3, 5'd0, 5'd0);
        commit_edge();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        @(negedge Clk);
        n_cmp++;
        if (rs_d !== 32'h00C0FFEE || count !== 16'd1) begin
            n_bad++;
            $display("FAIL coinc_first got %h cnt %0d want 00c0ffee cnt 1", rs_d, count);
        end
        commit_edge();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1;
        clear_model();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        @(posedge Clk);
        #1;
        test_reset();
        test_basic_write();
        test_zero_write();
        test_bypass();
        test_random();
        test_mid_reset();
        test_wrap();
        test_reset_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
